// File: rtl/adder_join_ctrl_if.sv
// Stream handshake bundle around the four-channel sample adder.
// slave is the join controller's view; master is the view of the surrounding streams.
interface adder_join_ctrl_if;
  logic [3:0] s_tvalid;
  logic [3:0] s_tlast;
  logic [3:0] s_tready;
  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;

  modport slave (
    input  s_tvalid,
    input  s_tlast,
    input  m_tready,
    output s_tready,
    output m_tvalid,
    output m_tlast
  );

  modport master (
    output s_tvalid,
    output s_tlast,
    output m_tready,
    input  s_tready,
    input  m_tvalid,
    input  m_tlast
  );
endinterface

// File: rtl/adder_join_ctrl.sv
// Join/flow controller for the four-channel sample adder: joins enabled input beats,
// strobes the adder register and flushes to the next frame boundary when a channel stalls.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | frame boundary; latch channel enables, no input is ready
// RUN   | join enabled channels; fire when all are valid and output slot free
// FLUSH | discard beats until every enabled channel saw tlast or idle limit
module adder_join_ctrl #(
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 ch_enable,
  input  logic                       err_clear,
  adder_join_ctrl_if.slave           bus,
  output logic                       add_en,
  output logic [3:0]                 add_zero_mask,
  output logic                       err_timeout,
  output logic                       err_tlast,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [1:0]                 state
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                     state_q, state_nxt;
  logic [3:0]                 en_q;
  logic [3:0]                 zmask_q;
  logic [3:0]                 done_q;
  logic [TW-1:0]              tmr_q;
  logic                       mvalid_q;
  logic                       mlast_q;
  logic                       err_to_q;
  logic                       err_tl_q;
  logic [FRAME_CNT_WIDTH-1:0] fcnt_q;

  logic [3:0] rdy;
  logic [3:0] tlast_en;
  logic       all_v;
  logic       any_v;
  logic       partial;
  logic       fire;
  logic       tlast_any;
  logic       tlast_bad;
  logic       tmr_tc;
  logic       timeout_hit;
  logic       flush_done;
  logic       accepted;

  assign all_v       = &(bus.s_tvalid | ~en_q);
  assign any_v       = |(bus.s_tvalid & en_q);
  assign partial     = any_v & ~all_v;
  assign fire        = (state_q == ST_RUN) & all_v & (~mvalid_q | bus.m_tready);
  assign tlast_en    = bus.s_tlast & en_q;
  assign tlast_any   = |tlast_en;
  assign tlast_bad   = fire & tlast_any & (tlast_en != en_q);
  // Down-counter: reload means "no partial/idle cycles seen", zero is the last allowed one.
  assign tmr_tc      = (tmr_q == '0);
  assign timeout_hit = (state_q == ST_RUN) & partial & tmr_tc;
  assign flush_done  = ((done_q | ~en_q) == 4'hF);
  assign accepted    = |(bus.s_tvalid & rdy);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ch_enable != 4'h0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire && tlast_any) begin
          state_nxt = ST_IDLE;
        end else if (timeout_hit) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_done || tmr_tc) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy = 4'h0;
    case (state_q)
      ST_RUN:   rdy = {4{fire}} & en_q;
      ST_FLUSH: rdy = en_q & ~done_q;
      default:  rdy = 4'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tmr_q <= TMR_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fire || !any_v || timeout_hit) begin
            tmr_q <= TMR_LOAD;
          end else if (partial) begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        ST_FLUSH: begin
          if (accepted) begin
            tmr_q <= TMR_LOAD;
          end else if (!tmr_tc) begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: tmr_q <= TMR_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q     <= 4'h0;
      zmask_q  <= 4'hF;
      done_q   <= 4'h0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      err_to_q <= 1'b0;
      err_tl_q <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        en_q    <= ch_enable;
        zmask_q <= ~ch_enable;
      end

      // A fire during a drain handshake replaces the old beat, so valid stays high.
      if (fire) begin
        mvalid_q <= 1'b1;
        mlast_q  <= tlast_any;
      end else if (mvalid_q && bus.m_tready) begin
        mvalid_q <= 1'b0;
      end

      if (timeout_hit) begin
        done_q <= 4'h0;
      end else if (state_q == ST_FLUSH) begin
        done_q <= done_q | (bus.s_tvalid & rdy & bus.s_tlast);
      end

      if (fire && tlast_any) begin
        fcnt_q <= fcnt_q + FRAME_CNT_WIDTH'(1);
      end

      if (err_clear) begin
        err_to_q <= 1'b0;
        err_tl_q <= 1'b0;
      end else begin
        err_to_q <= err_to_q | timeout_hit;
        err_tl_q <= err_tl_q | tlast_bad;
      end
    end
  end

  assign bus.s_tready  = rdy;
  assign bus.m_tvalid  = mvalid_q;
  assign bus.m_tlast   = mlast_q;
  assign add_en        = fire;
  assign add_zero_mask = zmask_q;
  assign err_timeout   = err_to_q;
  assign err_tlast     = err_tl_q;
  assign frame_count   = fcnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_adder_join_ctrl.sv
// Bench for adder_join_ctrl: fixed vector table, directed corner sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_adder_join_ctrl;
  localparam int T = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  ch_enable;
  logic        err_clear;
  logic        add_en;
  logic [3:0]  add_zero_mask;
  logic        err_timeout;
  logic        err_tlast;
  logic [15:0] frame_count;
  logic [1:0]  state;

  adder_join_ctrl_if bus ();

  adder_join_ctrl #(.TIMEOUT_CYCLES(T), .FRAME_CNT_WIDTH(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .ch_enable     (ch_enable),
    .err_clear     (err_clear),
    .bus           (bus),
    .add_en        (add_en),
    .add_zero_mask (add_zero_mask),
    .err_timeout   (err_timeout),
    .err_tlast     (err_tlast),
    .frame_count   (frame_count),
    .state         (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0/1/2 = idle/run/flush, run-lengths kept as plain integers.
  int          md;
  logic [3:0]  m_en, m_zm, m_done;
  logic        m_mv, m_ml, m_et, m_el;
  logic [15:0] m_fc;
  int          m_run;
  logic [3:0]  e_rdy;
  logic        e_fire;

  task automatic model_reset();
    md = 0; m_en = 4'h0; m_zm = 4'hF; m_done = 4'h0;
    m_mv = 1'b0; m_ml = 1'b0; m_et = 1'b0; m_el = 1'b0;
    m_fc = 16'd0; m_run = 0;
  endtask

  task automatic model_comb();
    logic slot_free;
    slot_free = !m_mv || bus.m_tready;
    e_fire = (md == 1) && ((bus.s_tvalid | ~m_en) == 4'hF) && slot_free;
    if (md == 1)      e_rdy = e_fire ? m_en : 4'h0;
    else if (md == 2) e_rdy = m_en & ~m_done;
    else              e_rdy = 4'h0;
  endtask

  task automatic model_update();
    logic [3:0] tle, acc;
    logic       allv, anyv, et_set, el_set, leave;
    model_comb();
    if (reset) begin
      model_reset();
    end else begin
      allv   = ((bus.s_tvalid | ~m_en) == 4'hF);
      anyv   = (bus.s_tvalid & m_en) != 4'h0;
      tle    = bus.s_tlast & m_en;
      acc    = bus.s_tvalid & e_rdy;
      et_set = 1'b0;
      el_set = e_fire && (tle != 4'h0) && (tle != m_en);
      if (e_fire) begin
        m_mv = 1'b1;
        m_ml = (tle != 4'h0);
      end else if (bus.m_tready) begin
        m_mv = 1'b0;
      end
      if (md == 0) begin
        m_en = ch_enable; m_zm = ~ch_enable; m_run = 0;
        if (ch_enable != 4'h0) md = 1;
      end else if (md == 1) begin
        if (e_fire) begin
          m_run = 0;
          if (tle != 4'h0) begin m_fc = m_fc + 16'd1; md = 0; end
        end else if (anyv && !allv) begin
          m_run = m_run + 1;
          if (m_run == T) begin md = 2; et_set = 1'b1; m_done = 4'h0; m_run = 0; end
        end else if (!anyv) begin
          m_run = 0;
        end
      end else begin
        leave  = ((m_done | ~m_en) == 4'hF) || (m_run == T - 1);
        m_done = m_done | (acc & bus.s_tlast);
        m_run  = (acc != 4'h0) ? 0 : m_run + 1;
        if (leave) md = 0;
      end
      if (err_clear) begin m_et = 1'b0; m_el = 1'b0; end
      else begin m_et = m_et | et_set; m_el = m_el | el_set; end
    end
  endtask

  logic seen_add_en;

  task automatic check_and_clock();
    model_comb();
    seen_add_en = add_en;
    chk("s_tready", bus.s_tready, e_rdy);
    chk("add_en", add_en, e_fire);
    chk("add_zero_mask", add_zero_mask, m_zm);
    chk("m_tvalid", bus.m_tvalid, m_mv);
    chk("m_tlast", bus.m_tlast, m_ml);
    chk("err_timeout", err_timeout, m_et);
    chk("err_tlast", err_tlast, m_el);
    chk("frame_count", frame_count, m_fc);
    chk("state", state, md[1:0]);
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step();
    @(negedge clock);
    check_and_clock();
  endtask

  task automatic drive(input logic [3:0] ce, input logic [3:0] tv, input logic [3:0] tl,
                       input logic mr, input logic clr);
    ch_enable = ce; bus.s_tvalid = tv; bus.s_tlast = tl; bus.m_tready = mr; err_clear = clr;
  endtask

  typedef struct {
    logic [3:0]  ce, tv, tl;
    logic        mr, clr;
    logic [1:0]  st;
    logic [3:0]  rdy;
    logic        aen, mv, ml;
    logic [3:0]  zm;
    logic        el;
    logic [15:0] fc;
  } vec_t;

  vec_t tbl[9];
  int   fires, beat, n;
  logic [3:0] silent;

  initial begin
    tbl[0] = '{4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 16'd0};
    tbl[1] = '{4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 2'd1, 4'h5, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 16'd0};
    tbl[2] = '{4'h5, 4'h4, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0, 1'b1, 1'b0, 4'hA, 1'b0, 16'd0};
    tbl[3] = '{4'h5, 4'hF, 4'h0, 1'b1, 1'b0, 2'd1, 4'h5, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 16'd0};
    tbl[4] = '{4'h5, 4'h5, 4'h1, 1'b1, 1'b0, 2'd1, 4'h5, 1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 16'd0};
    tbl[5] = '{4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1, 16'd1};
    tbl[6] = '{4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 16'd1};
    tbl[7] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 16'd1};
    tbl[8] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 16'd1};

    model_reset();
    reset = 1'b1;
    drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;

    // Vector table: enable mask 0101, partial cycle, mismatched tlast, drain in IDLE, err_clear.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].ce, tbl[i].tv, tbl[i].tl, tbl[i].mr, tbl[i].clr);
      @(negedge clock);
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_s_tready", bus.s_tready, tbl[i].rdy);
      chk("tbl_add_en", add_en, tbl[i].aen);
      chk("tbl_m_tvalid", bus.m_tvalid, tbl[i].mv);
      chk("tbl_m_tlast", bus.m_tlast, tbl[i].ml);
      chk("tbl_zero_mask", add_zero_mask, tbl[i].zm);
      chk("tbl_err_tlast", err_tlast, tbl[i].el);
      chk("tbl_frame_count", frame_count, tbl[i].fc);
      check_and_clock();
    end

    // Three 8-beat frames at full rate: 24 fires in 27 cycles.
    fires = 0; beat = 0;
    drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
    for (int c = 0; c < 27; c++) begin
      bus.s_tlast = (beat == 7) ? 4'hF : 4'h0;
      step();
      if (seen_add_en) begin
        fires++;
        beat = (beat == 7) ? 0 : beat + 1;
      end
    end
    chk("frames_fires", fires, 24);
    chk("frames_count", frame_count, 16'd4);
    chk("frames_err_timeout", err_timeout, 1'b0);
    chk("frames_err_tlast", err_tlast, 1'b0);

    // Back-pressure: one fire in 5 stalled cycles, no timeout, then resume.
    drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
    step();
    bus.m_tready = 1'b0;
    fires = 0;
    for (int c = 0; c < 5; c++) begin step(); if (seen_add_en) fires++; end
    chk("bp_fires", fires, 1);
    chk("bp_state", state, 2'd1);
    chk("bp_s_tready", bus.s_tready, 4'h0);
    bus.m_tready = 1'b1;
    fires = 0;
    for (int c = 0; c < 3; c++) begin step(); if (seen_add_en) fires++; end
    chk("bp_resume_fires", fires, 3);

    // Timeout: S21 silent; flush after exactly 4 partial cycles, then idle limit.
    drive(4'hF, 4'h7, 4'h0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step();
    chk("to_before_limit", state, 2'd1);
    step();
    chk("to_flush_entry", state, 2'd2);
    chk("to_err_timeout", err_timeout, 1'b1);
    drive(4'hF, 4'h7, 4'h7, 1'b1, 1'b0);
    step();
    drive(4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    n = 0;
    while (state == 2'd2 && n < 20) begin step(); n++; end
    chk("to_flush_idle_cycles", n, 4);
    chk("to_back_idle", state, 2'd0);

    // tlast disagreement, then err_clear clears both sticky errors but not frame_count.
    drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
    step();
    bus.s_tlast = 4'h3;
    step();
    chk("tl_m_tlast", bus.m_tlast, 1'b1);
    chk("tl_err_tlast", err_tlast, 1'b1);
    drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    step();
    err_clear = 1'b0;
    chk("clr_err_tlast", err_tlast, 1'b0);
    chk("clr_err_timeout", err_timeout, 1'b0);
    chk("clr_frame_count", frame_count, 16'd5);

    // Reset mid-frame with a pending output beat.
    drive(4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    step(); step();
    chk("rst_pre_m_tvalid", bus.m_tvalid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
    chk("rst_state", state, 2'd0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_zero_mask", add_zero_mask, 4'hF);

    // Randomized traffic against the model.
    silent = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0)
        silent = ($urandom_range(0, 3) == 0) ? (4'h1 << $urandom_range(0, 3)) : 4'h0;
      ch_enable = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      for (int b = 0; b < 4; b++) bus.s_tvalid[b] = ($urandom_range(0, 99) < 85);
      bus.s_tvalid = bus.s_tvalid & ~silent;
      if ($urandom_range(0, 7) == 0)
        bus.s_tlast = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      else
        bus.s_tlast = 4'h0;
      bus.m_tready = ($urandom_range(0, 3) != 0);
      err_clear = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
